// File: rtl/systolic_feeder.sv
// Operand skew feeder for an N x N output-stationary systolic MAC array.
// Captures A/B on start, then clears, feeds the diagonal wavefront, drains and flags done.
module systolic_feeder #(
  parameter int array_size = 3,
  parameter int data_size  = 8
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        start,
  input  logic [array_size*array_size*data_size-1:0]  a_mat,
  input  logic [array_size*array_size*data_size-1:0]  b_mat,
  output logic [array_size*data_size-1:0]             a_out,
  output logic [array_size*data_size-1:0]             b_out,
  output logic                                        mac_clr,
  output logic                                        busy,
  output logic                                        done
);
  localparam int N  = array_size;
  localparam int W  = data_size;
  localparam int TW = $clog2(2 * N);

  typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, DONE} state_t;

  state_t                 state;
  logic [TW-1:0]          t;
  logic [TW-1:0]          nt;
  logic [N*N*W-1:0]       a_reg;
  logic [N*N*W-1:0]       b_reg;
  logic [W-1:0]           a_lane [N];
  logic [W-1:0]           b_lane [N];
  logic [W-1:0]           a_nxt  [N];
  logic [W-1:0]           b_nxt  [N];

  // Lane values for the step about to be presented: the lane registers lead t by one edge.
  always_comb begin
    nt = (state == CLEAR) ? '0 : t + TW'(1);
    for (int i = 0; i < N; i++) begin
      a_nxt[i] = '0;
      b_nxt[i] = '0;
      for (int k = 0; k < N; k++) begin
        if (int'(nt) == i + k) begin
          a_nxt[i] = a_reg[(i*N+k)*W +: W];
          b_nxt[i] = b_reg[(k*N+i)*W +: W];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      t       <= '0;
      a_reg   <= '0;
      b_reg   <= '0;
      mac_clr <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      for (int i = 0; i < N; i++) begin
        a_lane[i] <= '0;
        b_lane[i] <= '0;
      end
    end else begin
      mac_clr <= 1'b0;
      done    <= 1'b0;
      for (int i = 0; i < N; i++) begin
        a_lane[i] <= '0;
        b_lane[i] <= '0;
      end
      case (state)
        IDLE: begin
          if (start) begin
            a_reg   <= a_mat;
            b_reg   <= b_mat;
            mac_clr <= 1'b1;
            busy    <= 1'b1;
            state   <= CLEAR;
          end
        end
        CLEAR: begin
          t     <= '0;
          state <= FEED;
          for (int i = 0; i < N; i++) begin
            a_lane[i] <= a_nxt[i];
            b_lane[i] <= b_nxt[i];
          end
        end
        FEED: begin
          if (t == TW'(2*N-2)) begin
            t     <= '0;
            state <= DRAIN;
          end else begin
            t <= nt;
            for (int i = 0; i < N; i++) begin
              a_lane[i] <= a_nxt[i];
              b_lane[i] <= b_nxt[i];
            end
          end
        end
        // t is reused as the drain cycle counter.
        DRAIN: begin
          if (t == TW'(N-1)) begin
            t     <= '0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            t <= t + TW'(1);
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_lane
    assign a_out[gi*W +: W] = a_lane[gi];
    assign b_out[gi*W +: W] = b_lane[gi];
  end

endmodule

// File: tb/tb_systolic_feeder.sv
// Scoreboard bench for systolic_feeder with a behavioural 3x3 output-stationary MAC array.
module tb_systolic_feeder;
  localparam int N = 3;
  localparam int W = 8;

  logic               clk;
  logic               rst;
  logic               start;
  logic [N*N*W-1:0]   a_mat;
  logic [N*N*W-1:0]   b_mat;
  logic [N*W-1:0]     a_out;
  logic [N*W-1:0]     b_out;
  logic               mac_clr;
  logic               busy;
  logic               done;

  systolic_feeder #(.array_size(N), .data_size(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a_mat(a_mat), .b_mat(b_mat),
    .a_out(a_out), .b_out(b_out), .mac_clr(mac_clr), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural MAC array: a flows right, b flows down, cleared by mac_clr or rst.
  int           acc [N][N];
  logic [W-1:0] ah  [N][N];
  logic [W-1:0] bv  [N][N];
  logic [W-1:0] ain [N][N];
  logic [W-1:0] bin [N][N];

  always_comb begin
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        ain[i][j] = (j == 0) ? a_out[i*W +: W] : ah[i][(j == 0) ? 0 : j-1];
        bin[i][j] = (i == 0) ? b_out[j*W +: W] : bv[(i == 0) ? 0 : i-1][j];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (rst || mac_clr) begin
          acc[i][j] <= 0;
          ah[i][j]  <= '0;
          bv[i][j]  <= '0;
        end else begin
          acc[i][j] <= acc[i][j] + int'(ain[i][j]) * int'(bin[i][j]);
          ah[i][j]  <= ain[i][j];
          bv[i][j]  <= bin[i][j];
        end
      end
    end
  end

  typedef struct {
    logic [N*W-1:0]    a;
    logic [N*W-1:0]    b;
    logic              clr;
    logic              bsy;
    logic              dn;
    logic [N*N*32-1:0] c;
  } rec_t;

  rec_t sb[$];
  int   am [N][N];
  int   bm [N][N];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic set_mats();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        a_mat[(i*N+j)*W +: W] = W'(am[i][j]);
        b_mat[(i*N+j)*W +: W] = W'(bm[i][j]);
      end
  endtask

  // Expected per-cycle outputs for cycles 1..3N+1 after the accepting edge.
  task automatic push_run();
    rec_t              r;
    logic [N*N*32-1:0] c;
    c = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        int s;
        s = 0;
        for (int k = 0; k < N; k++) s += am[i][k] * bm[k][j];
        c[(i*N+j)*32 +: 32] = 32'(s);
      end
    for (int cy = 1; cy <= 3*N+1; cy++) begin
      r.a   = '0;
      r.b   = '0;
      r.clr = (cy == 1);
      r.bsy = 1'b1;
      r.dn  = (cy == 3*N+1);
      r.c   = c;
      if (cy >= 2 && cy <= 2*N) begin
        for (int i = 0; i < N; i++) begin
          int k;
          k = (cy - 2) - i;
          if (k >= 0 && k < N) begin
            r.a[i*W +: W] = W'(am[i][k]);
            r.b[i*W +: W] = W'(bm[k][i]);
          end
        end
      end
      sb.push_back(r);
    end
  endtask

  task automatic push_idle(int n);
    rec_t r;
    r.a = '0; r.b = '0; r.clr = 1'b0; r.bsy = 1'b0; r.dn = 1'b0; r.c = '0;
    for (int q = 0; q < n; q++) sb.push_back(r);
  endtask

  task automatic step();
    rec_t r;
    @(negedge clk);
    if (sb.size() > 0) begin
      r = sb.pop_front();
      chk("a_out", 64'(a_out), 64'(r.a));
      chk("b_out", 64'(b_out), 64'(r.b));
      chk("mac_clr", 64'(mac_clr), 64'(r.clr));
      chk("busy", 64'(busy), 64'(r.bsy));
      chk("done", 64'(done), 64'(r.dn));
      if (r.dn) begin
        for (int i = 0; i < N; i++)
          for (int j = 0; j < N; j++)
            chk("mac_c", 64'(acc[i][j]), 64'(r.c[(i*N+j)*32 +: 32]));
      end
    end
  endtask

  task automatic load(int base, int bsel);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        am[i][j] = base + i*N + j;
        case (bsel)
          0:       bm[i][j] = (i == j) ? 1 : 0;
          1:       bm[i][j] = (i + 2*j) % 4;
          default: bm[i][j] = 3*i + j + 5;
        endcase
      end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; a_mat = '0; b_mat = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_clr", 64'(mac_clr), 64'd0);
    chk("rst_a", 64'(a_out), 64'd0);
    chk("rst_b", 64'(b_out), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Reference run: A = 1..9, B = identity, one-cycle start
    load(1, 0); set_mats();
    start = 1'b1; push_run();
    step(); start = 1'b0;
    repeat (3*N) step();
    push_idle(2); step(); step();

    // Restart pulse in cycle 5 and a_mat change in cycle 3 must be ignored
    load(10, 1); set_mats();
    start = 1'b1; push_run();
    step(); start = 1'b0;
    step(); a_mat = {(N*N*W/8){8'h5a}};
    step(); step(); start = 1'b1; b_mat = '1;
    step(); start = 1'b0;
    repeat (5) step();
    push_idle(2); step(); step();

    // Asynchronous reset during FEED t=2 aborts the run
    load(2, 2); set_mats();
    start = 1'b1; push_run();
    step(); start = 1'b0;
    step(); step(); step();
    sb.delete();
    #2 rst = 1'b1;
    #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_clr", 64'(mac_clr), 64'd0);
    chk("abort_a", 64'(a_out), 64'd0);
    chk("abort_b", 64'(b_out), 64'd0);
    @(negedge clk); rst = 1'b0;
    push_idle(2); step(); step();
    load(3, 1); set_mats();
    start = 1'b1; push_run();
    step(); start = 1'b0;
    repeat (3*N) step();
    push_idle(1); step();

    // Back-to-back runs with start held high; second run re-clears the array
    load(4, 2); set_mats();
    start = 1'b1; push_run();
    step(); step();
    load(20, 1); set_mats();
    repeat (3*N-1) step();
    push_idle(1); push_run();
    step(); step(); start = 1'b0;
    repeat (3*N) step();
    push_idle(2); step(); step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
